// File: rtl/jand_pulse_driver.sv
// jand_pulse_driver
//   Drives the two data inputs and the clock input of a clocked SFQ AND gate,
//   one operand bit pair per gate clock (LSB first), and captures the gate's
//   output pulses into a result word.
//
//   Ports
//     clk, rst       system clock, synchronous active-high reset
//     in_valid/ready operand handshake; in_ready is high only while idle
//     in_a, in_b     operand words for the dina / dinb pulse streams
//     dina, dinb     1-cycle data pulses to gate inputs A / B
//     gclk           1-cycle clock pulse to the gate
//     dout           gate output level; a rising edge is one pulse
//     res_valid      1-cycle result strobe (no backpressure)
//     res_data       bit i = pulse seen in response window i
//     res_mismatch   res_data differs from in_a & in_b
//     res_stray      edge outside a window, or a second edge inside one
module jand_pulse_driver #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 2,
   parameter int RESP_WIN  = 4,
   parameter int GAP_CYC   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             dina,
   output logic             dinb,
   output logic             gclk,
   input  logic             dout,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_mismatch,
   output logic             res_stray
);

   localparam int MAXC0 = (SETUP_CYC > RESP_WIN) ? SETUP_CYC : RESP_WIN;
   localparam int MAXC  = (MAXC0 > GAP_CYC) ? MAXC0 : GAP_CYC;
   localparam int CW    = ($clog2(MAXC + 1) < 1) ? 1 : $clog2(MAXC + 1);
   localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 2);
   localparam logic [CW-1:0] WAIT_LAST  = CW'(RESP_WIN - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
   localparam logic [IW-1:0] BIT_LAST   = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DATA, S_SETUP, S_CLK, S_WAIT, S_GAP, S_DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [IW-1:0]    bit_idx;
   logic [WIDTH-1:0] a_q, b_q;     // full operands, kept for the mismatch check
   logic [WIDTH-1:0] a_sh, b_sh;   // shifted so bit 0 is the current bit
   logic [WIDTH-1:0] a_nx, b_nx;
   logic [WIDTH-1:0] cap, cap_nxt;
   logic             stray_acc, stray_nxt;
   logic             hit, hit_nxt; // current window already saw an edge
   logic             dout_prev;
   logic             dedge;

   assign a_nx  = a_sh >> 1;
   assign b_nx  = b_sh >> 1;
   assign dedge = dout & ~dout_prev;

   // Scoring of the edge sampled in the current state. The final result is
   // built from these next values so an edge in the last WAIT cycle (or in the
   // last GAP cycle) still lands in the result presented in DONE.
   always_comb begin
      cap_nxt   = cap;
      stray_nxt = stray_acc;
      hit_nxt   = hit;
      if (dedge) begin
         unique case (state)
            S_WAIT: begin
               if (hit) begin
                  stray_nxt = 1'b1;
               end else begin
                  cap_nxt[bit_idx] = 1'b1;
                  hit_nxt          = 1'b1;
               end
            end
            S_DATA, S_SETUP, S_CLK, S_GAP: stray_nxt = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         bit_idx      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         a_sh         <= '0;
         b_sh         <= '0;
         cap          <= '0;
         stray_acc    <= 1'b0;
         hit          <= 1'b0;
         dout_prev    <= 1'b0;
         in_ready     <= 1'b1;
         dina         <= 1'b0;
         dinb         <= 1'b0;
         gclk         <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_mismatch <= 1'b0;
         res_stray    <= 1'b0;
      end else begin
         dout_prev <= dout;
         dina      <= 1'b0;
         dinb      <= 1'b0;
         gclk      <= 1'b0;
         res_valid <= 1'b0;
         cap       <= cap_nxt;
         stray_acc <= stray_nxt;
         hit       <= hit_nxt;

         // Outputs are registered: each transition also loads the pulse
         // values belonging to the state being entered.
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_q       <= in_a;
                  b_q       <= in_b;
                  a_sh      <= in_a;
                  b_sh      <= in_b;
                  bit_idx   <= '0;
                  cap       <= '0;
                  stray_acc <= 1'b0;
                  hit       <= 1'b0;
                  in_ready  <= 1'b0;
                  dina      <= in_a[0];
                  dinb      <= in_b[0];
                  state     <= S_DATA;
               end
            end
            S_DATA: begin
               cnt <= '0;
               if (SETUP_CYC > 1) begin
                  state <= S_SETUP;
               end else begin
                  gclk  <= 1'b1;
                  state <= S_CLK;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  gclk  <= 1'b1;
                  state <= S_CLK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_CLK: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT, S_GAP: begin
               if (state == S_WAIT && cnt != WAIT_LAST) begin
                  cnt <= cnt + 1'b1;
               end else if (state == S_WAIT && GAP_CYC > 0) begin
                  cnt   <= '0;
                  state <= S_GAP;
               end else if (state == S_GAP && cnt != GAP_LAST) begin
                  cnt <= cnt + 1'b1;
               end else if (bit_idx == BIT_LAST) begin
                  res_valid    <= 1'b1;
                  res_data     <= cap_nxt;
                  res_mismatch <= (cap_nxt != (a_q & b_q));
                  res_stray    <= stray_nxt;
                  state        <= S_DONE;
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  a_sh    <= a_nx;
                  b_sh    <= b_nx;
                  dina    <= a_nx[0];
                  dinb    <= b_nx[0];
                  hit     <= 1'b0;
                  state   <= S_DATA;
               end
            end
            S_DONE: begin
               in_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jand_pulse_driver.sv
// tb_jand_pulse_driver
//   Randomized bench for jand_pulse_driver. A reference model derives the
//   expected pulse timing and result from the bit-period arithmetic and a
//   per-cycle dout waveform table.
module tb_jand_pulse_driver;

   localparam int W     = 8;
   localparam int S     = 2;
   localparam int R     = 4;
   localparam int G     = 2;
   localparam int P     = S + 1 + R + G;
   localparam int DONEC = 1 + W * P;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b;
   logic         dina, dinb, gclk;
   logic         dout;
   logic         res_valid;
   logic [W-1:0] res_data;
   logic         res_mismatch;
   logic         res_stray;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit dv [0:127];

   jand_pulse_driver #(
      .WIDTH(W), .SETUP_CYC(S), .RESP_WIN(R), .GAP_CYC(G)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b),
      .dina(dina), .dinb(dinb), .gclk(gclk),
      .dout(dout),
      .res_valid(res_valid), .res_data(res_data),
      .res_mismatch(res_mismatch), .res_stray(res_stray)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic clear_dv();
      for (int k = 0; k < 128; k++) dv[k] = 1'b0;
   endtask

   // Gate that answers every a&b bit 'dly' cycles after gclk, level held 'wid' cycles.
   task automatic gate_dv(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int dly, input int wid);
      clear_dv();
      for (int i = 0; i < W; i++)
         if (a[i] & b[i])
            for (int k = 0; k < wid; k++) dv[1 + i * P + S + dly + k] = 1'b1;
   endtask

   // Expected result from the dout table: windows are offsets S+1..S+R of each bit period.
   task automatic model(output logic [W-1:0] rd, output logic st);
      rd = '0;
      st = 1'b0;
      for (int c = 1; c < DONEC; c++) begin
         if (dv[c] && !dv[c-1]) begin
            int off = (c - 1) % P;
            int i   = (c - 1) / P;
            if (off > S && off <= S + R) begin
               if (rd[i]) st = 1'b1;
               else       rd[i] = 1'b1;
            end else begin
               st = 1'b1;
            end
         end
      end
   endtask

   task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] rd;
      logic         st;
      model(rd, st);
      check("ready_idle", in_ready, 1);
      in_a = a; in_b = b; in_valid = 1'b1; dout = dv[0];
      tick(); cyc = 1;
      for (int c = 1; c <= DONEC; c++) begin
         logic ea, eb, eg;
         ea = 1'b0; eb = 1'b0; eg = 1'b0;
         // busy: keep offering junk words, which must be ignored
         in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
         dout = dv[c];
         if (c < DONEC) begin
            int off = (c - 1) % P;
            int i   = (c - 1) / P;
            ea = (off == 0) & a[i];
            eb = (off == 0) & b[i];
            eg = (off == S);
         end
         check("dina", dina, ea);
         check("dinb", dinb, eb);
         check("gclk", gclk, eg);
         check("ready_busy", in_ready, 0);
         check("res_valid", res_valid, (c == DONEC) ? 1 : 0);
         if (c == DONEC) begin
            check("res_data", res_data, rd);
            check("res_mismatch", res_mismatch, (rd != (a & b)) ? 1 : 0);
            check("res_stray", res_stray, st);
         end
         tick(); cyc++;
      end
      in_valid = 1'b0; dout = 1'b0;
      check("ready_after", in_ready, 1);
      check("valid_after", res_valid, 0);
      check("data_hold", res_data, rd);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_dina"}, dina, 0);
      check({tag, "_dinb"}, dinb, 0);
      check({tag, "_gclk"}, gclk, 0);
      check({tag, "_valid"}, res_valid, 0);
      check({tag, "_data"}, res_data, 0);
      check({tag, "_mism"}, res_mismatch, 0);
      check({tag, "_stray"}, res_stray, 0);
      check({tag, "_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; dout = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_quiet("reset");

      // directed cases
      gate_dv(8'hFF, 8'h0F, 2, 1); run_txn(8'hFF, 8'h0F);
      gate_dv(8'h01, 8'h01, 2, 1); run_txn(8'h01, 8'h01);
      gate_dv(8'h01, 8'h01, 5, 1); run_txn(8'h01, 8'h01);
      gate_dv(8'h80, 8'h80, 1, 3); run_txn(8'h80, 8'h80);
      gate_dv(8'h80, 8'h80, 1, 3); dv[DONEC - 1] = 1'b1; run_txn(8'h80, 8'h80);
      gate_dv(8'h80, 8'h80, R, 1); run_txn(8'h80, 8'h80);   // edge in last WAIT cycle
      gate_dv(8'h01, 8'h01, 0, 1); run_txn(8'h01, 8'h01);   // edge coincident with gclk

      // reset mid-transaction
      gate_dv(8'hAA, 8'hFF, 2, 1);
      in_a = 8'hAA; in_b = 8'hFF; in_valid = 1'b1; dout = dv[0];
      tick(); cyc = 1; in_valid = 1'b0;
      for (int c = 1; c < 30; c++) begin dout = dv[c]; tick(); cyc++; end
      rst = 1'b1;
      tick(); cyc++;
      rst = 1'b0;
      check_quiet("midrst");
      for (int c = 0; c < 90; c++) begin
         dout = 1'($urandom);
         check("midrst_novalid", res_valid, 0);
         tick(); cyc++;
      end
      dout = 1'b0;

      // randomized transactions, back to back
      for (int t = 0; t < 24; t++) begin
         ra = W'($urandom); rb = W'($urandom);
         case ($urandom_range(0, 3))
            0: gate_dv(ra, rb, 2, 1);
            1: gate_dv(ra, rb, $urandom_range(0, 7), $urandom_range(1, 3));
            2: begin
                  clear_dv();
                  for (int k = 1; k < DONEC + 2; k++) dv[k] = ($urandom_range(0, 5) == 0);
               end
            default: begin
                  gate_dv(ra, rb, $urandom_range(1, R), 1);
                  dv[$urandom_range(1, DONEC - 1)] = 1'b1;
               end
         endcase
         run_txn(ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
